// File: rtl/nocif_tx_arbiter_pkg.sv
// Shared NoC sizing and arbiter types; the header burst flag is the MSB of the header.
// Requesters, the arbiter and the NoC TX side all take the header and payload widths from here.
package nocif_tx_arbiter_pkg;

   localparam int NOC_HEADER_SIZE  = 16;
   localparam int NOC_PAYLOAD_SIZE = 32;

   typedef struct packed {
      logic                       burst;
      logic [NOC_HEADER_SIZE-2:0] body;
   } noc_hdr_t;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_BURST = 1'b1
   } arb_state_e;

endpackage

// File: rtl/nocif_rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr_i, wrapping; no latency.
// Pure function of its inputs, so it has no backpressure of its own.
module nocif_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               gnt_vld_o,
   output logic [IDX_W-1:0]   gnt_idx_o
);

   // Walk offsets from farthest to nearest so the nearest asserted request wins.
   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[i] && (i == (int'(ptr_i) + k) % NUM_REQ)) begin
               gnt_vld_o = 1'b1;
               gnt_idx_o = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/nocif_tx_arbiter.sv
// Round-robin flit arbiter with burst locking onto the NoC TX side; 1-cycle latency, 1 flit/cycle.
// A stalled full output register holds out_* and keeps every req_stall_o high.
module nocif_tx_arbiter
   import nocif_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                                 clk_i,
   input  logic                                 reset_q_i,
   input  logic [NUM_REQ-1:0]                   req_wrreq_i,
   input  logic [NUM_REQ*NOC_HEADER_SIZE-1:0]   req_header_i,
   input  logic [NUM_REQ*NOC_PAYLOAD_SIZE-1:0]  req_payload_i,
   output logic [NUM_REQ-1:0]                   req_stall_o,
   output logic                                 out_wrreq_o,
   output logic [NOC_HEADER_SIZE-1:0]           out_header_o,
   output logic [NOC_PAYLOAD_SIZE-1:0]          out_payload_o,
   input  logic                                 out_stall_i,
   output logic [$clog2(NUM_REQ)-1:0]           grant_id_o,
   output logic                                 burst_err_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam int HW    = NOC_HEADER_SIZE;
   localparam int PW    = NOC_PAYLOAD_SIZE;

   arb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]      lock_q, lock_d;
   logic [IDX_W-1:0]      grant_q, grant_d;
   logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
   logic                  burst_err_q, burst_err_d;
   logic                  out_vld_q, out_vld_d;
   noc_hdr_t              out_hdr_q, out_hdr_d;
   logic [PW-1:0]         out_pay_q, out_pay_d;

   logic                  rr_vld;
   logic [IDX_W-1:0]      rr_idx;
   logic                  lock_req;
   logic                  gnt_vld;
   logic [IDX_W-1:0]      gnt_idx;
   logic                  load_en;
   logic                  accept;
   noc_hdr_t              sel_hdr;
   logic [PW-1:0]         sel_pay;

   nocif_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_i     (req_wrreq_i),
      .ptr_i     (rr_ptr_q),
      .gnt_vld_o (rr_vld),
      .gnt_idx_o (rr_idx)
   );

   // Grant selection; during a burst only the locked requester can be served.
   always_comb begin
      lock_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (lock_q == IDX_W'(i)) lock_req = req_wrreq_i[i];
      end
      if (state_q == ST_BURST) begin
         gnt_vld = lock_req;
         gnt_idx = lock_q;
      end else begin
         gnt_vld = rr_vld;
         gnt_idx = rr_idx;
      end
      load_en = !out_vld_q || !out_stall_i;
      // Gating with reset keeps every requester stalled while reset is held.
      accept  = load_en && gnt_vld && reset_q_i;
   end

   always_comb begin
      sel_hdr     = '0;
      sel_pay     = '0;
      req_stall_o = '1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == IDX_W'(i)) begin
            sel_hdr        = noc_hdr_t'(req_header_i[i*HW +: HW]);
            sel_pay        = req_payload_i[i*PW +: PW];
            req_stall_o[i] = !accept;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      lock_d      = lock_q;
      grant_d     = grant_q;
      burst_cnt_d = burst_cnt_q;
      burst_err_d = burst_err_q;
      out_vld_d   = out_vld_q;
      out_hdr_d   = out_hdr_q;
      out_pay_d   = out_pay_q;
      if (load_en) out_vld_d = accept;
      if (accept) begin
         out_hdr_d = sel_hdr;
         out_pay_d = sel_pay;
         grant_d   = gnt_idx;
         case (state_q)
            ST_ARB: begin
               rr_ptr_d = gnt_idx;
               if (sel_hdr.burst) begin
                  state_d     = ST_BURST;
                  lock_d      = gnt_idx;
                  burst_cnt_d = CNT_W'(1);
               end
            end
            ST_BURST: begin
               if (sel_hdr.burst) begin
                  // Over-long bursts are flagged but keep the lock so the flit stream stays intact.
                  if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) burst_err_d = 1'b1;
                  if (burst_cnt_q != CNT_W'(MAX_BURST)) burst_cnt_d = burst_cnt_q + 1'b1;
               end else begin
                  state_d     = ST_ARB;
                  rr_ptr_d    = lock_q;
                  burst_cnt_d = '0;
               end
            end
            default: state_d = ST_ARB;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_q_i) begin
      if (!reset_q_i) begin
         state_q     <= ST_ARB;
         rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
         lock_q      <= '0;
         grant_q     <= '0;
         burst_cnt_q <= '0;
         burst_err_q <= 1'b0;
         out_vld_q   <= 1'b0;
         out_hdr_q   <= '0;
         out_pay_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_q      <= lock_d;
         grant_q     <= grant_d;
         burst_cnt_q <= burst_cnt_d;
         burst_err_q <= burst_err_d;
         out_vld_q   <= out_vld_d;
         out_hdr_q   <= out_hdr_d;
         out_pay_q   <= out_pay_d;
      end
   end

   assign out_wrreq_o   = out_vld_q;
   assign out_header_o  = out_hdr_q;
   assign out_payload_o = out_pay_q;
   assign grant_id_o    = grant_q;
   assign burst_err_o   = burst_err_q;

endmodule

// File: tb/tb_nocif_tx_arbiter.sv
// Bench for nocif_tx_arbiter: directed scenarios plus random traffic against a flit-level reference model.
module tb_nocif_tx_arbiter;
   import nocif_tx_arbiter_pkg::*;

   localparam int NREQ = 4;
   localparam int MAXB = 4;
   localparam int HW   = NOC_HEADER_SIZE;
   localparam int PW   = NOC_PAYLOAD_SIZE;

   logic                 clk = 1'b0;
   logic                 reset_q = 1'b0;
   logic [NREQ-1:0]      req_wrreq = '0;
   logic [NREQ*HW-1:0]   req_header = '0;
   logic [NREQ*PW-1:0]   req_payload = '0;
   logic [NREQ-1:0]      req_stall;
   logic                 out_wrreq;
   logic [HW-1:0]        out_header;
   logic [PW-1:0]        out_payload;
   logic                 out_stall = 1'b0;
   logic [1:0]           grant_id;
   logic                 burst_err;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model state: flit-level view of the arbitration rules.
   int            m_last;
   bit            m_locked;
   int            m_lock;
   int            m_cnt;
   bit            m_err;
   bit            m_vld;
   logic [HW-1:0] m_hdr;
   logic [PW-1:0] m_pay;
   int            m_gid;

   always #5 clk = ~clk;

   nocif_tx_arbiter #(.NUM_REQ(NREQ), .MAX_BURST(MAXB)) dut (
      .clk_i         (clk),
      .reset_q_i     (reset_q),
      .req_wrreq_i   (req_wrreq),
      .req_header_i  (req_header),
      .req_payload_i (req_payload),
      .req_stall_o   (req_stall),
      .out_wrreq_o   (out_wrreq),
      .out_header_o  (out_header),
      .out_payload_o (out_payload),
      .out_stall_i   (out_stall),
      .grant_id_o    (grant_id),
      .burst_err_o   (burst_err)
   );

   task automatic m_reset();
      m_last = NREQ - 1; m_locked = 0; m_lock = 0; m_cnt = 0; m_err = 0;
      m_vld = 0; m_hdr = '0; m_pay = '0; m_gid = 0;
   endtask

   task automatic drive_all(input logic [NREQ-1:0] vld, input logic [NREQ-1:0] burst);
      logic [HW-1:0] h;
      for (int i = 0; i < NREQ; i++) begin
         h = HW'($urandom);
         h[HW-1] = burst[i];
         req_header[i*HW +: HW]  = h;
         req_payload[i*PW +: PW] = PW'($urandom);
      end
      req_wrreq = vld;
   endtask

   // One clock: predict who is accepted, check stalls, advance model, check registered outputs.
   task automatic cycle();
      int w;
      logic [NREQ-1:0] exp_stall;
      logic [HW-1:0] h;
      #1;
      w = -1;
      if (!(m_vld && out_stall)) begin
         if (m_locked) begin
            if (req_wrreq[m_lock]) w = m_lock;
         end else begin
            for (int k = 1; k <= NREQ; k++) begin
               int idx;
               idx = (m_last + k) % NREQ;
               if (w < 0 && req_wrreq[idx]) w = idx;
            end
         end
      end
      exp_stall = '1;
      if (w >= 0) exp_stall[w] = 1'b0;
      n_cmp++;
      if (req_stall !== exp_stall) begin
         n_fail++;
         $display("FAIL stall: got %b want %b at %0t", req_stall, exp_stall, $time);
      end
      @(posedge clk);
      if (!(m_vld && out_stall)) begin
         m_vld = (w >= 0);
         if (w >= 0) begin
            h = req_header[w*HW +: HW];
            m_hdr = h; m_pay = req_payload[w*PW +: PW]; m_gid = w;
            if (!m_locked) begin
               m_last = w;
               if (h[HW-1]) begin m_locked = 1; m_lock = w; m_cnt = 1; end
            end else if (h[HW-1]) begin
               if (m_cnt == MAXB - 1) m_err = 1;
               if (m_cnt < MAXB) m_cnt++;
            end else begin
               m_locked = 0; m_last = m_lock;
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if (out_wrreq !== m_vld) begin
         n_fail++;
         $display("FAIL out_wrreq: got %b want %b at %0t", out_wrreq, m_vld, $time);
      end
      if (m_vld) begin
         n_cmp++;
         if (out_header !== m_hdr || out_payload !== m_pay || grant_id !== 2'(m_gid)) begin
            n_fail++;
            $display("FAIL out_flit: got %h/%h/%0d want %h/%h/%0d at %0t",
                     out_header, out_payload, grant_id, m_hdr, m_pay, m_gid, $time);
         end
      end
      n_cmp++;
      if (burst_err !== m_err) begin
         n_fail++;
         $display("FAIL burst_err: got %b want %b at %0t", burst_err, m_err, $time);
      end
   endtask

   task automatic test_reset();
      drive_all('1, '0);
      #1;
      n_cmp++;
      if (out_wrreq !== 1'b0 || out_header !== '0 || out_payload !== '0 ||
          grant_id !== 2'd0 || burst_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b/%h/%h/%0d/%b want all zero",
                  out_wrreq, out_header, out_payload, grant_id, burst_err);
      end
      n_cmp++;
      if (req_stall !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_stall: got %b want 1111", req_stall);
      end
      @(negedge clk);
      reset_q = 1'b1;
      m_reset();
   endtask

   task automatic test_round_robin();
      int exp_g[5] = '{0, 1, 2, 3, 0};
      n_cmp++;
      if (out_wrreq !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_idle: got out_wrreq %b want 0", out_wrreq);
      end
      for (int n = 0; n < 5; n++) begin
         drive_all(4'b1111, 4'b0000);
         cycle();
         n_cmp++;
         if (out_wrreq !== 1'b1 || grant_id !== 2'(exp_g[n])) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got vld %b id %0d want vld 1 id %0d", n, out_wrreq, grant_id, exp_g[n]);
         end
      end
   endtask

   task automatic test_burst();
      logic [NREQ-1:0] vld[6]   = '{4'b0100, 4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b1111};
      logic [NREQ-1:0] bst[6]   = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
      int              exp_g[6] = '{2, 2, -1, 2, 2, 3};
      for (int n = 0; n < 6; n++) begin
         drive_all(vld[n], bst[n]);
         cycle();
         n_cmp++;
         if (exp_g[n] < 0) begin
            if (out_wrreq !== 1'b0) begin
               n_fail++;
               $display("FAIL burst_locked_idle: got out_wrreq %b want 0", out_wrreq);
            end
         end else if (out_wrreq !== 1'b1 || grant_id !== 2'(exp_g[n])) begin
            n_fail++;
            $display("FAIL burst_grant%0d: got vld %b id %0d want vld 1 id %0d", n, out_wrreq, grant_id, exp_g[n]);
         end
      end
      n_cmp++;
      if (burst_err !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_no_err: got %b want 0", burst_err);
      end
   endtask

   task automatic test_stall();
      logic [HW-1:0] held_hdr;
      logic [HW-1:0] next_hdr;
      drive_all(4'b1111, 4'b0000);
      held_hdr = req_header[0*HW +: HW];
      cycle();
      out_stall = 1'b1;
      for (int n = 0; n < 5; n++) begin
         drive_all(4'b1111, 4'b0000);
         cycle();
         n_cmp++;
         if (out_wrreq !== 1'b1 || out_header !== held_hdr || grant_id !== 2'd0 || req_stall !== 4'hF) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got %b/%h/%0d/%b want 1/%h/0/1111",
                     n, out_wrreq, out_header, grant_id, req_stall, held_hdr);
         end
      end
      out_stall = 1'b0;
      drive_all(4'b1111, 4'b0000);
      next_hdr = req_header[1*HW +: HW];
      #1;
      n_cmp++;
      if (req_stall !== 4'b1101) begin
         n_fail++;
         $display("FAIL stall_release: got %b want 1101", req_stall);
      end
      cycle();
      n_cmp++;
      if (out_wrreq !== 1'b1 || out_header !== next_hdr || grant_id !== 2'd1) begin
         n_fail++;
         $display("FAIL stall_reload: got %b/%h/%0d want 1/%h/1", out_wrreq, out_header, grant_id, next_hdr);
      end
   endtask

   task automatic test_burst_err();
      bit exp_e[5] = '{0, 0, 0, 1, 1};
      for (int n = 0; n < 5; n++) begin
         if (n == 0) drive_all(4'b0010, 4'b0010);
         else        drive_all(4'b1111, 4'b1111);
         cycle();
         n_cmp++;
         if (burst_err !== exp_e[n] || grant_id !== 2'd1 || out_wrreq !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_err_flit%0d: got err %b id %0d want err %b id 1", n + 1, burst_err, grant_id, exp_e[n]);
         end
      end
      drive_all(4'b1101, 4'b1111);
      cycle();
      n_cmp++;
      if (burst_err !== 1'b1 || out_wrreq !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_err_lock: got err %b vld %b want err 1 vld 0", burst_err, out_wrreq);
      end
      drive_all(4'b1111, 4'b0000);
      cycle();
      n_cmp++;
      if (grant_id !== 2'd1 || burst_err !== 1'b1) begin
         n_fail++;
         $display("FAIL burst_err_end: got id %0d err %b want id 1 err 1", grant_id, burst_err);
      end
   endtask

   task automatic test_reset_mid_burst();
      for (int n = 0; n < 2; n++) begin
         drive_all(4'b1111, 4'b1111);
         cycle();
      end
      #2 reset_q = 1'b0;
      #1;
      n_cmp++;
      if (out_wrreq !== 1'b0 || burst_err !== 1'b0 || out_header !== '0 || req_stall !== 4'hF) begin
         n_fail++;
         $display("FAIL midburst_reset: got %b/%b/%h/%b want 0/0/0/1111", out_wrreq, burst_err, out_header, req_stall);
      end
      m_reset();
      @(negedge clk);
      reset_q = 1'b1;
      drive_all(4'b0000, 4'b0000);
      cycle();
      n_cmp++;
      if (out_wrreq !== 1'b0) begin
         n_fail++;
         $display("FAIL midburst_replay: got out_wrreq %b want 0", out_wrreq);
      end
      drive_all(4'b1111, 4'b0000);
      cycle();
      n_cmp++;
      if (out_wrreq !== 1'b1 || grant_id !== 2'd0) begin
         n_fail++;
         $display("FAIL midburst_first_grant: got vld %b id %0d want vld 1 id 0", out_wrreq, grant_id);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive_all(NREQ'($urandom), NREQ'($urandom & $urandom & $urandom));
         out_stall = ($urandom_range(0, 9) < 3);
         cycle();
      end
      out_stall = 1'b0;
   endtask

   initial begin
      m_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_round_robin();
      test_burst();
      test_stall();
      test_burst_err();
      test_reset_mid_burst();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/nocif_tx_arbiter.md
NOCIF_TX_ARBITER -- requirements
Module: nocif_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of module-side requesters, range 2..8.
REQ-002 SHALL have parameter MAX_BURST, default 16: maximum flits allowed in one burst.
REQ-003 SHALL have port clk_i, input, 1: clock.
REQ-004 SHALL have port reset_q_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_wrreq_i, input, NUM_REQ: per-requester flit valid.
REQ-006 SHALL have port req_header_i, input, NUM_REQ*NOC_HEADER_SIZE: per-requester header; requester i occupies slice i; the burst bit is the slice MSB.
REQ-007 SHALL have port req_payload_i, input, NUM_REQ*NOC_PAYLOAD_SIZE: per-requester payload.
REQ-008 SHALL have port req_stall_o, output, NUM_REQ: per-requester stall; a flit is accepted when req_wrreq_i[i] && !req_stall_o[i].
REQ-009 SHALL have port out_wrreq_o, output, 1: flit valid towards the NoC interface TX side.
REQ-010 SHALL have port out_header_o, output, NOC_HEADER_SIZE: forwarded header.
REQ-011 SHALL have port out_payload_o, output, NOC_PAYLOAD_SIZE: forwarded payload.
REQ-012 SHALL have port out_stall_i, input, 1: downstream stall.
REQ-013 SHALL have port grant_id_o, output, clog2(NUM_REQ): index of the requester that supplied the flit on out_*.
REQ-014 SHALL have port burst_err_o, output, 1: sticky flag for a burst-length violation.

Function
REQ-015 SHALL hold the flit, grant_id_o and valid in a one-entry output register, so latency from acceptance to out_wrreq_o is 1 cycle.
REQ-016 SHALL load the output register when it is empty or when it is draining (out_wrreq_o && !out_stall_i) in the same cycle, giving 1 flit/cycle throughput.
REQ-017 SHALL keep out_* stable while out_wrreq_o && out_stall_i.
REQ-018 SHALL assert req_stall_o[i] low only for the granted requester in a cycle where the register loads; all others SHALL see stall high.
REQ-019 SHALL implement an FSM with states ARB and BURST.
REQ-020 In ARB, SHALL grant round-robin among asserted req_wrreq_i, starting at the index after the last accepted requester (rr_ptr).
REQ-021 In ARB, if an accepted flit has burst=1, SHALL go to BURST, lock to that requester and set burst_cnt=1.
REQ-022 In BURST, SHALL serve only the locked requester; other requests wait with stall high even when the locked requester is idle.
REQ-023 In BURST, each accepted flit SHALL increment burst_cnt; a flit with burst=0 SHALL end the burst, return the FSM to ARB and set rr_ptr to the locked index.
REQ-024 If a flit with burst=1 is accepted when burst_cnt==MAX_BURST-1, SHALL set burst_err_o and keep the lock; burst_cnt SHALL saturate at MAX_BURST.
REQ-025 A non-burst flit accepted in ARB SHALL update rr_ptr and leave the FSM in ARB.
REQ-026 With no requests, SHALL keep rr_ptr unchanged and stay in ARB.
REQ-027 SHALL forward header and payload bit-exact, with no field modification.

Reset
REQ-028 On reset_q_i low, SHALL immediately set: out_wrreq_o=0, out_header_o=0, out_payload_o=0, grant_id_o=0, burst_err_o=0, FSM=ARB, rr_ptr=NUM_REQ-1 (so requester 0 has first priority), burst_cnt=0.
REQ-029 req_stall_o SHALL be all ones during reset.
REQ-030 A reset during a burst SHALL discard the burst lock and any buffered flit; no flit is replayed.

Structure
REQ-031 NOC_HEADER_SIZE and NOC_PAYLOAD_SIZE SHALL come from the shared NoC parameter include, and the burst-bit position SHALL be derived from NOC_HEADER_SIZE.
REQ-032 SHALL use one sub-module, nocif_rr_arbiter: a combinational round-robin grant from request vector and rr_ptr. All other logic SHALL be in the top module.

Verification
REQ-033 Reset, then req_wrreq_i=4'b1111 with non-burst flits and out_stall_i=0 -> grants 0,1,2,3,0 on consecutive cycles; out_wrreq_o first asserts 1 cycle after the first accept.
REQ-034 Requester 2 sends a 4-flit burst (burst=1,1,1,0) while requesters 0, 1 and 3 request -> grant_id_o=2 for 4 flits with no interleaving, then grant goes to 3.
REQ-035 out_stall_i=1 for 5 cycles with a full register -> out_* held constant, all req_stall_o=1; release -> flit drains and a new flit loads in the same cycle.
REQ-036 MAX_BURST=4, requester 1 sends 5 flits all with burst=1 -> burst_err_o rises on flit 4, stays high, and the lock is held.
REQ-037 Assert reset mid-burst at flit 2 -> out_wrreq_o=0 and burst_err_o=0 immediately; after release, requester 0 is granted first.
